// File: rtl/relu_quant_maxpool.sv
// ReLU + round-half-up requantization + 2x2 stride-2 max pooling over a raster conv stream.
// Optional macro SAT_COUNT_EN adds sat_count, a per-frame count of saturated samples.
module relu_quant_maxpool #(
    parameter int ACC_WIDTH  = 29,
    parameter int DATA_WIDTH = 8,
    parameter int ROW_LEN    = 220,
    parameter int NUM_ROWS   = 220,
    parameter int SHIFT      = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic signed [ACC_WIDTH-1:0] conv_in,
    input  logic                        conv_in_valid,
    output logic [DATA_WIDTH-1:0]       pool_out,
    output logic                        pool_out_valid,
    output logic                        frame_done
`ifdef SAT_COUNT_EN
    ,
    output logic [15:0]                 sat_count
`endif
);
    localparam int CW   = (ROW_LEN  > 1) ? $clog2(ROW_LEN)  : 1;
    localparam int RW   = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam int HALF = ROW_LEN / 2;
    localparam int LW   = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [ACC_WIDTH:0] RND  = {{ACC_WIDTH{1'b0}}, 1'b1} << (SHIFT - 1);
    localparam logic [ACC_WIDTH:0] QMAX = {{(ACC_WIDTH+1-DATA_WIDTH){1'b0}}, {DATA_WIDTH{1'b1}}};

    logic [ACC_WIDTH:0]    sum, t;
    logic                  neg, over;
    logic [DATA_WIDTH-1:0] q_next, q;
    logic                  q_valid;
`ifdef SAT_COUNT_EN
    logic                  q_over;
`endif

    // One extra bit of headroom keeps the rounding add from wrapping.
    always_comb begin
        neg    = conv_in[ACC_WIDTH-1];
        sum    = {1'b0, conv_in} + RND;
        t      = sum >> SHIFT;
        over   = !neg && (t > QMAX);
        q_next = neg ? '0 : (over ? '1 : t[DATA_WIDTH-1:0]);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q       <= '0;
            q_valid <= 1'b0;
`ifdef SAT_COUNT_EN
            q_over  <= 1'b0;
`endif
        end else begin
            q_valid <= conv_in_valid;
            if (conv_in_valid) begin
                q <= q_next;
`ifdef SAT_COUNT_EN
                q_over <= over;
`endif
            end
        end
    end

    logic [CW-1:0]         col;
    logic [RW-1:0]         row;
    logic [DATA_WIDTH-1:0] hold, m, lb_rd;
    logic [LW-1:0]         lb_idx;
    logic                  last_col, last_row;
    logic [DATA_WIDTH-1:0] linebuf [HALF];

    assign last_col = (col == CW'(ROW_LEN - 1));
    assign last_row = (row == RW'(NUM_ROWS - 1));
    assign lb_idx   = LW'(col >> 1);
    assign m        = (q > hold) ? q : hold;
    assign lb_rd    = linebuf[lb_idx];

    // An odd trailing column or row never reaches an odd/odd position, so it is dropped naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col            <= '0;
            row            <= '0;
            hold           <= '0;
            pool_out       <= '0;
            pool_out_valid <= 1'b0;
            frame_done     <= 1'b0;
        end else begin
            pool_out_valid <= 1'b0;
            frame_done     <= 1'b0;
            if (q_valid) begin
                if (!col[0]) begin
                    hold <= q;
                end else if (row[0]) begin
                    pool_out       <= (lb_rd > m) ? lb_rd : m;
                    pool_out_valid <= 1'b1;
                end
                if (last_col && last_row)
                    frame_done <= 1'b1;
                if (last_col) begin
                    col <= '0;
                    row <= last_row ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

    // Written in even rows, read in odd rows: no reset needed.
    always_ff @(posedge clk) begin
        if (q_valid && col[0] && !row[0])
            linebuf[lb_idx] <= m;
    end

`ifdef SAT_COUNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            sat_count <= '0;
        else if (q_valid) begin
            if (col == '0 && row == '0)
                sat_count <= {15'd0, q_over};
            else if (q_over && sat_count != 16'hFFFF)
                sat_count <= sat_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_relu_quant_maxpool.sv
// Scoreboard bench: three DUTs (2x2, 4x4, 5x3) driven from one sequence, outputs checked at negedge.
module tb_relu_quant_maxpool;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic signed [28:0] cin [3];
    logic               cv  [3];
    logic [7:0]         po  [3];
    logic               pv  [3];
    logic               fd  [3];
`ifdef SAT_COUNT_EN
    logic [15:0]        sat [3];
`endif

    int RL [3] = '{2, 4, 5};
    int NR [3] = '{2, 4, 3};

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int eq [3][$];
    int ed [3][$];
    int fq [3][$];
    int qa [3][5][5];
    int mr [3];
    int mc [3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        relu_quant_maxpool #(
            .ACC_WIDTH (29),
            .DATA_WIDTH(8),
            .ROW_LEN   (g == 0 ? 2 : (g == 1 ? 4 : 5)),
            .NUM_ROWS  (g == 0 ? 2 : (g == 1 ? 4 : 3)),
            .SHIFT     (8)
        ) u_dut (
            .clk           (clk),
            .rst           (rst),
            .conv_in       (cin[g]),
            .conv_in_valid (cv[g]),
            .pool_out      (po[g]),
            .pool_out_valid(pv[g]),
            .frame_done    (fd[g])
`ifdef SAT_COUNT_EN
            ,
            .sat_count     (sat[g])
`endif
        );
    end

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int quant(input longint v);
        longint t;
        if (v < 0) return 0;
        t = (v + 128) / 256;
        return (t > 255) ? 255 : int'(t);
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Called on the negedge that presents the sample; it is captured at the next posedge.
    task automatic send(input int d, input longint v);
        int r, c;
        r = mr[d];
        c = mc[d];
        cin[d] = 29'(v);
        cv[d]  = 1'b1;
        qa[d][r][c] = quant(v);
        if (r % 2 == 1 && c % 2 == 1) begin
            eq[d].push_back(max2(max2(qa[d][r-1][c-1], qa[d][r-1][c]),
                                 max2(qa[d][r][c-1],   qa[d][r][c])));
            ed[d].push_back(cyc + 2);
        end
        if (r == NR[d] - 1 && c == RL[d] - 1)
            fq[d].push_back(cyc + 2);
        if (c == RL[d] - 1) begin
            mc[d] = 0;
            mr[d] = (r == NR[d] - 1) ? 0 : r + 1;
        end else begin
            mc[d] = c + 1;
        end
        @(negedge clk);
        cv[d] = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // mode 0: ramp (r*RL+c)<<8, mode 1: constant 2^20
    task automatic frame(input int d, input int mode, input int gapmax);
        for (int r = 0; r < NR[d]; r++)
            for (int c = 0; c < RL[d]; c++) begin
                send(d, (mode == 0) ? longint'((r * RL[d] + c) * 256) : 64'sd1048576);
                if (gapmax > 0) idle($urandom_range(0, gapmax));
            end
    endtask

    task automatic do_rst(input int n);
        rst = 1'b0;
        for (int d = 0; d < 3; d++) begin
            eq[d].delete(); ed[d].delete(); fq[d].delete();
            mr[d] = 0; mc[d] = 0;
        end
        idle(n);
        rst = 1'b1;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            for (int d = 0; d < 3; d++) begin
                if (pv[d]) begin
                    if (eq[d].size() == 0) chk($sformatf("unexp_out%0d", d), 1, 0);
                    else begin
                        chk($sformatf("pool%0d", d), int'(po[d]), eq[d][0]);
                        chk($sformatf("lat%0d", d), cyc, ed[d][0]);
                        void'(eq[d].pop_front());
                        void'(ed[d].pop_front());
                    end
                end else if (ed[d].size() > 0 && ed[d][0] <= cyc) begin
                    chk($sformatf("missing_out%0d", d), cyc, ed[d][0]);
                    void'(eq[d].pop_front());
                    void'(ed[d].pop_front());
                end
                if (fd[d]) begin
                    if (fq[d].size() == 0) chk($sformatf("unexp_fd%0d", d), 1, 0);
                    else begin
                        chk($sformatf("fd_lat%0d", d), cyc, fq[d][0]);
                        void'(fq[d].pop_front());
                    end
                end else if (fq[d].size() > 0 && fq[d][0] <= cyc) begin
                    chk($sformatf("missing_fd%0d", d), cyc, fq[d][0]);
                    void'(fq[d].pop_front());
                end
            end
        end
    end

    initial begin
        for (int d = 0; d < 3; d++) begin
            cin[d] = '0; cv[d] = 1'b0; mr[d] = 0; mc[d] = 0;
        end
        // Reset with valid asserted: outputs must stay quiet.
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin cin[d] = 29'sd70000; cv[d] = 1'b1; end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                chk("rst_po", int'(po[d]), 0);
                chk("rst_pv", int'(pv[d]), 0);
                chk("rst_fd", int'(fd[d]), 0);
            end
        end
        for (int d = 0; d < 3; d++) cv[d] = 1'b0;
        rst = 1'b1;
        idle(2);

        // Quantization on 2x2: relu, rounding, saturation, wide positive.
        send(0, 384); send(0, -5); send(0, 70000); send(0, 0);
        send(0, 127); send(0, 128); send(0, 0); send(0, 0);
        send(0, 640); send(0, 639); send(0, 0); send(0, -1000);
        send(0, 268435455); send(0, 0); send(0, -268435456); send(0, 383);
        idle(4);

        // Pooling 4x4 contiguous, back-to-back, then with gaps.
        frame(1, 0, 0);
        frame(1, 0, 0);
        idle(4);
        frame(1, 0, 3);
        idle(4);

        // Reset mid-frame after 6 samples, then a full frame.
        for (int i = 0; i < 6; i++) send(1, 64'sd65280);
        do_rst(1);
        frame(1, 0, 0);
        idle(4);

        // Odd dimensions 5x3, saturating frame then ramp frame.
        frame(2, 1, 0);
        idle(4);
`ifdef SAT_COUNT_EN
        chk("sat_count_full", int'(sat[2]), 15);
`endif
        frame(2, 0, 1);
        idle(4);
`ifdef SAT_COUNT_EN
        chk("sat_count_clear", int'(sat[2]), 0);
`endif
        idle(4);
        for (int d = 0; d < 3; d++)
            chk($sformatf("leftover%0d", d), eq[d].size() + fq[d].size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/relu_quant_maxpool.md
Name: relu_quant_maxpool

Overview:
- Downstream stage of the second conv layer.
- Consumes the summed signed convolution stream (one accumulator value per cycle when valid, raster order) and applies ReLU.
- Requantizes to DATA_WIDTH unsigned with round-half-up and saturation.
- Performs 2x2 stride-2 max pooling using a half-row line buffer, emitting one pooled pixel per 2x2 block to the next layer's window generator.

Parameters:
- ACC_WIDTH, 29, width of signed input accumulator (2*DATA_WIDTH+13).
- DATA_WIDTH, 8, width of unsigned output pixel.
- ROW_LEN, 220, conv outputs per row (IMAGE_SIZE-2); must be >= 2.
- NUM_ROWS, 220, conv output rows per frame; must be >= 2.
- SHIFT, 8, right-shift applied during requantization; must be >= 1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- conv_in  input  ACC_WIDTH  signed two's-complement conv sum.
- conv_in_valid  input  1  conv_in valid this cycle; no backpressure, gaps allowed.
- pool_out  output  DATA_WIDTH  pooled pixel.
- pool_out_valid  output  1  one-cycle strobe per pooled pixel.
- frame_done  output  1  one-cycle pulse at end of frame.

Behaviour:
- Reset (rst=0, asynchronous): pool_out=0, pool_out_valid=0, frame_done=0; col/row counters=0; pair-hold register=0; stage-1 valid=0. Line-buffer contents are don't-care, because each entry is written in the even row before it is read in the odd row.
- Stage 1, registered, 1 cycle:
  - If conv_in < 0, q = 0.
  - Otherwise t = (conv_in + 2^(SHIFT-1)) >> SHIFT, computed at ACC_WIDTH+1 bits, so no overflow.
  - q = min(t, 2^DATA_WIDTH-1).
  - q_valid follows conv_in_valid.
- Counters: col (0..ROW_LEN-1) and row (0..NUM_ROWS-1) advance on each q_valid. col wraps to 0 and increments row; row wraps to 0 after the last row.
- Stage 2, registered, 1 cycle, acting on q_valid only:
  - Even col: hold <= q.
  - Odd col: m = max(hold, q).
    - Even row: linebuf[col>>1] <= m.
    - Odd row: pool_out <= max(linebuf[col>>1], m) and pool_out_valid <= 1.
- Line buffer: ROW_LEN/2 entries x DATA_WIDTH. Simultaneous read and write of the same index cannot occur, since even rows only write and odd rows only read.
- Odd dimensions:
  - If ROW_LEN is odd, the last column is consumed (counter advances) but never pooled.
  - If NUM_ROWS is odd, the last row is consumed but produces no output.
- Latency: pool_out_valid is asserted exactly 2 cycles after the conv_in_valid cycle carrying the odd-row, odd-col sample that completes the block.
- frame_done: pulses 2 cycles after the conv_in_valid cycle carrying sample (NUM_ROWS-1, ROW_LEN-1). It coincides with the last pool_out_valid when both dimensions are even.
- Throughput: accepts 1 sample/cycle indefinitely; output rate is at most 1 per 4 inputs.
- Idle cycles (conv_in_valid=0) freeze all state. Outputs hold their value, but valid strobes drop to 0.
- Reset mid-frame: counters return to (0,0); the next accepted sample is treated as frame start; no partial block is emitted.
- Back-to-back frames need no idle gap.

Optional Feature:
- Macro SAT_COUNT_EN.
- When defined: adds output port sat_count [15:0]. It counts stage-1 samples where t > 2^DATA_WIDTH-1, saturating at 16'hFFFF. It resets to 0 on rst and clears to 0 on the first sample of each frame; the cleared value already includes that first sample.
- When undefined: the port and counter are absent, and behaviour is otherwise identical.

Test Plan (SHIFT=8 unless noted):
- Reset: hold rst=0 for 3 cycles with conv_in_valid=1 -> pool_out=0, pool_out_valid=0, frame_done=0 throughout.
- Quantization (ROW_LEN=2, NUM_ROWS=2): feed conv_in = 384, -5, 70000, 0 -> q = 2, 0, 255, 0; one output pool_out=255, with frame_done on the same cycle, 2 cycles after the 4th sample.
- Pooling (ROW_LEN=4, NUM_ROWS=4): conv_in = (row*4+col)<<8, contiguous -> pool_out = 5, 7, 13, 15; frame_done coincides with 15.
- Gaps: same frame with random 0-3 idle cycles between samples -> identical outputs 5, 7, 13, 15, each 2 cycles after its completing sample.
- Reset mid-frame: after 6 samples assert rst for 1 cycle, then send the full 4x4 frame -> exactly 4 outputs 5, 7, 13, 15 and no stale output.
- Odd dimensions (ROW_LEN=5, NUM_ROWS=3): conv_in = (row*5+col)<<8 -> pool_out = 6, 8 only; frame_done 2 cycles after sample (2,4); with SAT_COUNT_EN and all inputs 2^20, sat_count = 15.
